stream_wrr_arbiter: RTL and testbench

- Weighted round-robin arbiter sharing one valid/ready output stream between N_INP input streams. AXI4-style handshake dependency rules apply.
- A granted input keeps the output for a burst of up to weight_i[idx] handshakes. The grant is released early when that input drops valid after a handshake.
- Sits in front of shared stream consumers (memory request ports, response muxes) where plain per-beat round-robin fragments bursts.

---
 rtl/stream_wrr_pkg.sv | 14 +
 rtl/rr_pick_idx.sv | 36 +++
 rtl/stream_wrr_arbiter.sv | 117 +++++++++++
 tb/tb_stream_wrr_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_wrr_pkg.sv
// Shared types for the weighted round-robin stream arbiter: FSM states and
// the grant-index width helper.
package stream_wrr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } wrr_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick_idx.sv
// Round-robin picker: first set request at or above ptr_i, wrapping modulo N_INP.
// Rotate so ptr_i becomes bit 0, find the lowest set bit, then un-rotate.
module rr_pick_idx #(
  parameter int unsigned N_INP = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_INP-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [2*N_INP-1:0] req_dbl;
  logic [N_INP-1:0]   req_rot;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W:0]     idx_sum;

  assign req_dbl = {req_i, req_i} >> ptr_i;
  assign req_rot = req_dbl[N_INP-1:0];
  assign any_o   = |req_i;

  // Scan downward so the lowest set bit wins.
  always_comb begin
    offset = '0;
    for (int k = N_INP - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = IDX_W'(k);
    end
  end

  always_comb begin
    idx_sum = {1'b0, ptr_i} + {1'b0, offset};
    if (idx_sum >= (IDX_W + 1)'(N_INP)) idx_sum = idx_sum - (IDX_W + 1)'(N_INP);
    idx_o = idx_sum[IDX_W-1:0];
  end

endmodule

// File: rtl/stream_wrr_arbiter.sv
// Weighted round-robin arbiter: one granted input owns the output stream for
// up to weight_i[idx] beats, or until it drops valid after a handshake.
module stream_wrr_arbiter
  import stream_wrr_pkg::*;
#(
  parameter  int unsigned DATA_W   = 32,
  parameter  int unsigned N_INP    = 4,
  parameter  int unsigned WEIGHT_W = 4,
  localparam int unsigned IDX_W    = idx_w(N_INP)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic [N_INP*WEIGHT_W-1:0] weight_i,
  input  logic [N_INP*DATA_W-1:0]   inp_data_i,
  input  logic [N_INP-1:0]          inp_valid_i,
  output logic [N_INP-1:0]          inp_ready_o,
  output logic [DATA_W-1:0]         oup_data_o,
  output logic                      oup_valid_o,
  input  logic                      oup_ready_i,
  output logic [IDX_W-1:0]          gnt_idx_o,
  output logic                      burst_active_o
);

  // Handshake: a beat transfers when oup_valid_o && oup_ready_i at a rising
  // edge; valid never depends on ready, and the selected input's ready is
  // oup_ready_i passed straight through.
  wrr_state_e          state_q;
  logic [IDX_W-1:0]    cur_idx_q, rr_ptr_q;
  logic [WEIGHT_W-1:0] beat_cnt_q, limit_q;

  logic [IDX_W-1:0]    pick, sel_idx;
  logic [WEIGHT_W-1:0] pick_weight, eff_weight, beat_inc;
  logic                any_valid, hs;

  rr_pick_idx #(
    .N_INP (N_INP),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i (inp_valid_i),
    .ptr_i (rr_ptr_q),
    .idx_o (pick),
    .any_o (any_valid)
  );

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_INP - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  assign sel_idx     = (state_q == GRANT) ? cur_idx_q : pick;
  assign pick_weight = weight_i[pick*WEIGHT_W +: WEIGHT_W];
  assign eff_weight  = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
  assign beat_inc    = beat_cnt_q + WEIGHT_W'(1);

  always_comb begin
    oup_data_o  = inp_data_i[sel_idx*DATA_W +: DATA_W];
    gnt_idx_o   = sel_idx;
    oup_valid_o = 1'b0;
    inp_ready_o = '0;
    if (!flush_i) begin
      oup_valid_o          = (state_q == GRANT) ? inp_valid_i[sel_idx] : any_valid;
      inp_ready_o[sel_idx] = oup_ready_i;
    end
  end

  assign hs             = oup_valid_o && oup_ready_i;
  assign burst_active_o = (state_q == GRANT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cur_idx_q  <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      limit_q    <= '0;
    end else if (flush_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            limit_q   <= eff_weight;
            cur_idx_q <= pick;
            // Single-beat grants complete without ever leaving IDLE.
            if (hs && eff_weight == WEIGHT_W'(1)) begin
              rr_ptr_q <= next_idx(pick);
            end else begin
              state_q    <= GRANT;
              beat_cnt_q <= hs ? WEIGHT_W'(1) : '0;
            end
          end
        end
        GRANT: begin
          if (!inp_valid_i[cur_idx_q] || (hs && beat_inc == limit_q)) begin
            state_q    <= IDLE;
            rr_ptr_q   <= next_idx(cur_idx_q);
            beat_cnt_q <= '0;
          end else if (hs) begin
            beat_cnt_q <= beat_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(inp_ready_o));
  a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (oup_valid_o && !oup_ready_i && !flush_i) |=> (flush_i || $stable(oup_data_o)));
  a_n_inp: assert property (@(posedge clk_i) N_INP >= 1);
`endif

endmodule

// File: tb/tb_stream_wrr_arbiter.sv
// Bench for stream_wrr_arbiter (N_INP=4): directed scenarios plus a randomized
// run against a burst-level reference model and an output scoreboard.
module tb_stream_wrr_arbiter;

  logic         clk_i, rst_ni, flush_i, oup_ready_i;
  logic [15:0]  weight_i;
  logic [127:0] inp_data_i;
  logic [3:0]   inp_valid_i, inp_ready_o;
  logic [31:0]  oup_data_o;
  logic         oup_valid_o, burst_active_o;
  logic [1:0]   gnt_idx_o;

  logic [3:0]   lane_v;
  logic [31:0]  lane_d [4];
  logic [3:0]   w4 [4];

  int checks = 0;
  int errors = 0;

  // Reference model: which input owns a burst (-1 = none), beats taken, limit, pointer.
  int          m_owner, m_taken, m_lim, m_ptr, hs_lane;
  logic        e_valid, e_active;
  logic [1:0]  e_idx;
  logic [31:0] e_data;
  logic [3:0]  e_ready;
  logic [31:0] exp_q [$];

  stream_wrr_arbiter #(.DATA_W(32), .N_INP(4), .WEIGHT_W(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .weight_i(weight_i),
    .inp_data_i(inp_data_i), .inp_valid_i(inp_valid_i), .inp_ready_o(inp_ready_o),
    .oup_data_o(oup_data_o), .oup_valid_o(oup_valid_o), .oup_ready_i(oup_ready_i),
    .gnt_idx_o(gnt_idx_o), .burst_active_o(burst_active_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  assign inp_valid_i = lane_v;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      inp_data_i[i*32 +: 32] = lane_d[i];
      weight_i[i*4 +: 4]     = w4[i];
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; flush_i = 1'b0; oup_ready_i = 1'b0; lane_v = '0;
    for (int i = 0; i < 4; i++) begin lane_d[i] = $urandom; w4[i] = 4'd1; end
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  function automatic int pick_ref();
    for (int k = 0; k < 4; k++) if (lane_v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return 0;
  endfunction

  task automatic model_outputs();
    int s;
    s        = (m_owner >= 0) ? m_owner : pick_ref();
    e_idx    = 2'(s);
    e_data   = lane_d[s];
    e_active = (m_owner >= 0);
    e_valid  = (m_owner >= 0) ? lane_v[s] : (lane_v != 0);
    e_ready  = oup_ready_i ? (4'b0001 << s) : 4'b0000;
    if (flush_i) begin e_valid = 1'b0; e_ready = 4'b0000; end
  endtask

  task automatic model_advance();
    int  p, lim;
    bit  hs;
    hs      = e_valid && oup_ready_i;
    hs_lane = hs ? int'(e_idx) : -1;
    if (flush_i) begin
      m_owner = -1; m_taken = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      if (lane_v != 0) begin
        p   = pick_ref();
        lim = (w4[p] == 0) ? 1 : int'(w4[p]);
        if (hs && lim == 1) m_ptr = (p + 1) % 4;
        else begin m_owner = p; m_lim = lim; m_taken = hs ? 1 : 0; end
      end
    end else if (!lane_v[m_owner] || (hs && m_taken + 1 == m_lim)) begin
      m_ptr = (m_owner + 1) % 4; m_owner = -1; m_taken = 0;
    end else if (hs) begin
      m_taken++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    checks++; if (burst_active_o !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", burst_active_o); end
    checks++; if (gnt_idx_o !== 2'd0) begin errors++; $display("FAIL reset_gnt: got %0d want 0", gnt_idx_o); end
    checks++; if (oup_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_idle: got %b want 0", oup_valid_o); end
    lane_v = 4'b0100;
    #1;
    checks++; if (oup_valid_o !== 1'b1 || gnt_idx_o !== 2'd2) begin errors++; $display("FAIL reset_comb_path: valid %b gnt %0d want 1/2", oup_valid_o, gnt_idx_o); end
    lane_v = 4'b0000;
    next_cycle();
  endtask

  task automatic test_rr_order();
    int e;
    do_reset();
    for (int i = 0; i < 4; i++) w4[i] = 4'd2;
    lane_v = 4'hf; oup_ready_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_i);
      e = (c / 2) % 4;
      checks++; if (gnt_idx_o !== 2'(e) || oup_valid_o !== 1'b1) begin errors++; $display("FAIL rr_order c%0d: gnt %0d valid %b want %0d/1", c, gnt_idx_o, oup_valid_o, e); end
      checks++; if (oup_data_o !== lane_d[e]) begin errors++; $display("FAIL rr_order_data c%0d: got %h want %h", c, oup_data_o, lane_d[e]); end
      next_cycle();
      lane_d[e] = $urandom;
    end
  endtask

  task automatic test_stall_lock();
    logic [31:0] d;
    do_reset();
    w4[1] = 4'd3; lane_v = 4'b0010; d = lane_d[1];
    for (int c = 0; c < 9; c++) begin
      @(negedge clk_i);
      if (c < 5) begin
        checks++; if (oup_data_o !== d || gnt_idx_o !== 2'd1 || inp_ready_o !== 4'b0000) begin errors++; $display("FAIL stall_hold c%0d: data %h gnt %0d rdy %b want %h/1/0000", c, oup_data_o, gnt_idx_o, inp_ready_o, d); end
      end else if (c < 8) begin
        checks++; if (gnt_idx_o !== 2'd1 || inp_ready_o !== 4'b0010) begin errors++; $display("FAIL stall_beats c%0d: gnt %0d rdy %b want 1/0010", c, gnt_idx_o, inp_ready_o); end
      end else begin
        checks++; if (gnt_idx_o !== 2'd2 || inp_ready_o !== 4'b0100) begin errors++; $display("FAIL stall_next_ptr: gnt %0d rdy %b want 2/0100", gnt_idx_o, inp_ready_o); end
      end
      next_cycle();
      if (c == 1) lane_v = lane_v | 4'b0101;
      if (c == 4) oup_ready_i = 1'b1;
      if (c >= 5) lane_d[1] = $urandom;
    end
  endtask

  task automatic test_early_release();
    do_reset();
    w4[0] = 4'd8; w4[3] = 4'd2; lane_v = 4'b1001; oup_ready_i = 1'b1;
    @(negedge clk_i);
    checks++; if (gnt_idx_o !== 2'd0) begin errors++; $display("FAIL early_first: gnt %0d want 0", gnt_idx_o); end
    next_cycle(); lane_d[0] = $urandom;
    @(negedge clk_i);
    checks++; if (gnt_idx_o !== 2'd0 || burst_active_o !== 1'b1) begin errors++; $display("FAIL early_second: gnt %0d act %b want 0/1", gnt_idx_o, burst_active_o); end
    next_cycle(); lane_v[0] = 1'b0;
    @(negedge clk_i);
    checks++; if (oup_valid_o !== 1'b0 || burst_active_o !== 1'b1) begin errors++; $display("FAIL early_bubble: valid %b act %b want 0/1", oup_valid_o, burst_active_o); end
    next_cycle();
    @(negedge clk_i);
    checks++; if (gnt_idx_o !== 2'd3 || oup_valid_o !== 1'b1 || burst_active_o !== 1'b0) begin errors++; $display("FAIL early_switch: gnt %0d valid %b act %b want 3/1/0", gnt_idx_o, oup_valid_o, burst_active_o); end
    next_cycle(); lane_d[3] = $urandom;
    @(negedge clk_i);
    checks++; if (gnt_idx_o !== 2'd3 || burst_active_o !== 1'b1) begin errors++; $display("FAIL early_burst3: gnt %0d act %b want 3/1", gnt_idx_o, burst_active_o); end
    next_cycle();
  endtask

  task automatic test_zero_weight();
    logic [1:0] eg [4];
    logic       ea [4];
    eg = '{2'd2, 2'd3, 2'd3, 2'd2};
    ea = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    w4[2] = 4'd0; w4[3] = 4'd2; lane_v = 4'b1100; oup_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      checks++; if (gnt_idx_o !== eg[c] || burst_active_o !== ea[c]) begin errors++; $display("FAIL zero_weight c%0d: gnt %0d act %b want %0d/%b", c, gnt_idx_o, burst_active_o, eg[c], ea[c]); end
      next_cycle();
      lane_d[eg[c]] = $urandom;
    end
  endtask

  task automatic test_flush();
    do_reset();
    w4[2] = 4'd4; lane_v = 4'b0100; oup_ready_i = 1'b1;
    @(negedge clk_i);
    checks++; if (gnt_idx_o !== 2'd2) begin errors++; $display("FAIL flush_pre: gnt %0d want 2", gnt_idx_o); end
    next_cycle(); lane_d[2] = $urandom; flush_i = 1'b1;
    @(negedge clk_i);
    checks++; if (oup_valid_o !== 1'b0 || inp_ready_o !== 4'b0000) begin errors++; $display("FAIL flush_block: valid %b rdy %b want 0/0000", oup_valid_o, inp_ready_o); end
    next_cycle(); flush_i = 1'b0; lane_v[0] = 1'b1;
    @(negedge clk_i);
    checks++; if (burst_active_o !== 1'b0 || gnt_idx_o !== 2'd0 || inp_ready_o !== 4'b0001) begin errors++; $display("FAIL flush_after: act %b gnt %0d rdy %b want 0/0/0001", burst_active_o, gnt_idx_o, inp_ready_o); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    do_reset();
    w4[1] = 4'd3; lane_v = 4'b1010;
    next_cycle();
    @(negedge clk_i);
    checks++; if (burst_active_o !== 1'b1 || gnt_idx_o !== 2'd1) begin errors++; $display("FAIL areset_pre: act %b gnt %0d want 1/1", burst_active_o, gnt_idx_o); end
    #2 lane_v[0] = 1'b1; rst_ni = 1'b0;
    #1;
    checks++; if (burst_active_o !== 1'b0 || gnt_idx_o !== 2'd0) begin errors++; $display("FAIL areset_immediate: act %b gnt %0d want 0/0", burst_active_o, gnt_idx_o); end
    next_cycle(); rst_ni = 1'b1; oup_ready_i = 1'b1;
    @(negedge clk_i);
    checks++; if (gnt_idx_o !== 2'd0 || inp_ready_o !== 4'b0001) begin errors++; $display("FAIL areset_after: gnt %0d rdy %b want 0/0001", gnt_idx_o, inp_ready_o); end
    next_cycle();
  endtask

  task automatic test_random();
    logic [31:0] got;
    do_reset();
    m_owner = -1; m_taken = 0; m_lim = 1; m_ptr = 0;
    exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_i);
      model_outputs();
      checks++; if (oup_valid_o !== e_valid || burst_active_o !== e_active) begin errors++; $display("FAIL rand_valid c%0d: valid %b act %b want %b/%b", c, oup_valid_o, burst_active_o, e_valid, e_active); end
      if (e_valid) begin
        checks++; if (gnt_idx_o !== e_idx) begin errors++; $display("FAIL rand_gnt c%0d: got %0d want %0d", c, gnt_idx_o, e_idx); end
      end
      if (e_valid || e_active || flush_i) begin
        checks++; if (inp_ready_o !== e_ready) begin errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, inp_ready_o, e_ready); end
      end
      if (e_valid && oup_ready_i) exp_q.push_back(e_data);
      if (oup_valid_o && oup_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_sb_extra c%0d: got %h want no beat", c, oup_data_o); end
        else begin
          got = exp_q.pop_front();
          if (oup_data_o !== got) begin errors++; $display("FAIL rand_sb_data c%0d: got %h want %h", c, oup_data_o, got); end
        end
      end
      model_advance();
      next_cycle();
      for (int i = 0; i < 4; i++) begin
        if (hs_lane == i) begin
          if ($urandom_range(1) == 1) lane_d[i] = $urandom;
          else lane_v[i] = 1'b0;
        end else if (!lane_v[i] && $urandom_range(9) < 3) begin
          lane_v[i] = 1'b1; lane_d[i] = $urandom;
        end
        w4[i] = 4'($urandom_range(3));
      end
      oup_ready_i = ($urandom_range(3) != 0);
      flush_i     = ($urandom_range(39) == 0);
    end
    flush_i = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_sb_left: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_stall_lock();
    test_early_release();
    test_zero_weight();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
